// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and a 32-bit word RAM.
// Splits byte/half/word accesses (aligned or not) into one or two word accesses, stores via single-cycle RMW.
module mem_access_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t             r_state;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH-1:0]   r_buf;
  logic [WIDTH-1:0]   r_rdata;

  logic [2:0]         w_nbytes;
  logic [1:0]         w_off;
  logic               w_span;
  logic               w_phase1;
  logic [WIDTH-3:0]   w_word0;
  logic [WIDTH-3:0]   w_word1;
  logic [WIDTH-1:0]   w_merge;
  logic [WIDTH-1:0]   w_buf_nxt;

  function automatic logic [WIDTH-1:0] extend_load(input logic [WIDTH-1:0] b,
                                                   input logic [1:0] sz,
                                                   input logic uns);
    logic signed [7:0]  v8;
    logic signed [15:0] v16;
    v8  = b[7:0];
    v16 = b[15:0];
    case (sz)
      2'b00:   return uns ? {{(WIDTH-8){1'b0}}, b[7:0]}   : WIDTH'(v8);
      2'b01:   return uns ? {{(WIDTH-16){1'b0}}, b[15:0]} : WIDTH'(v16);
      default: return b;
    endcase
  endfunction

  assign w_nbytes = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;
  assign w_off    = r_addr[1:0];
  assign w_span   = ({1'b0, w_off} + w_nbytes) > 3'd4;
  assign w_phase1 = (r_state == S_ACC1);
  assign w_word0  = r_addr[WIDTH-1:2];
  assign w_word1  = r_addr[WIDTH-1:2] + 1'b1;

  // Lane l of the current word holds access byte k = l + 4*phase - offset, when 0 <= k < N.
  always_comb begin
    w_merge   = mem_rdata;
    w_buf_nxt = r_buf;
    for (int l = 0; l < 4; l++) begin
      logic [3:0] pos;
      logic [3:0] k;
      pos = 4'(l) + (w_phase1 ? 4'd4 : 4'd0);
      k   = pos - {2'b00, w_off};
      if ((pos >= {2'b00, w_off}) && (k < {1'b0, w_nbytes})) begin
        w_merge[8*l +: 8]        = r_wdata[8*k[1:0] +: 8];
        w_buf_nxt[8*k[1:0] +: 8] = mem_rdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (r_state)
      S_ACC0: begin
        mem_addr = {2'b00, w_word0};
        if (r_we) begin
          mem_we    = 1'b1;
          mem_wdata = w_merge;
        end
      end
      S_ACC1: begin
        mem_addr = {2'b00, w_word1};
        if (r_we) begin
          mem_we    = 1'b1;
          mem_wdata = w_merge;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;

  // Request fields are only consumed in the ACC states, so they need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_buf   <= '0;
            r_state <= S_ACC0;
          end
        end
        S_ACC0, S_ACC1: begin
          if (!r_we) r_buf <= w_buf_nxt;
          if (r_state == S_ACC0 && w_span) begin
            r_state <= S_ACC1;
          end else begin
            r_rdata <= r_we ? '0 : extend_load(w_buf_nxt, r_size, r_unsigned);
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
